gshare_branch_predictor: RTL and testbench

//  Frontend-side counterpart of conditional_branch. It predicts the take decision for

---
 rtl/gshare_branch_predictor.sv | 86 ++++++++
 tb/tb_gshare_branch_predictor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: a PHT of 2-bit saturating counters indexed by PC ^ GHR,
// with a speculative GHR that is repaired from the snapshot carried by a mispredicted branch.
module gshare_branch_predictor #(
  parameter int IDX_BITS  = 8,
  parameter int HIST_BITS = 8,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          pred_pc,
  input  logic                 pred_fire,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 resolve_valid,
  input  logic [31:0]          resolve_pc,
  input  logic [HIST_BITS-1:0] resolve_ghr,
  input  logic                 resolve_taken,
  input  logic                 resolve_mispred,
  output logic [HIST_BITS-1:0] ghr,
  output logic [CNT_BITS-1:0]  mispred_count
);

  localparam int PHT_N = 1 << IDX_BITS;

  logic [1:0]           r_pht [PHT_N];
  logic [HIST_BITS-1:0] r_ghr;
  logic [CNT_BITS-1:0]  r_mcnt;

  logic [IDX_BITS-1:0]  w_pred_idx;
  logic [IDX_BITS-1:0]  w_res_idx;
  logic                 w_recover;
  logic                 w_unused;

  // History is zero-extended into the upper index bits when it is narrower than the PHT index.
  function automatic logic [IDX_BITS-1:0] f_idx(input logic [31:0] pc,
                                                input logic [HIST_BITS-1:0] h);
    logic [IDX_BITS-1:0] hx;
    hx = '0;
    hx[HIST_BITS-1:0] = h;
    return pc[IDX_BITS+1:2] ^ hx;
  endfunction

  function automatic logic [1:0] f_sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] f_sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign w_pred_idx = f_idx(pred_pc, r_ghr);
  assign w_res_idx  = f_idx(resolve_pc, resolve_ghr);
  assign w_recover  = resolve_valid & resolve_mispred;

  assign pred_taken    = r_pht[w_pred_idx][1];
  assign pred_ghr      = r_ghr;
  assign ghr           = r_ghr;
  assign mispred_count = r_mcnt;

  assign w_unused = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                      resolve_pc[31:IDX_BITS+2], resolve_pc[1:0]};

  // The predict read above sees the pre-update counter; training lands at this edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
      r_ghr  <= '0;
      r_mcnt <= '0;
    end else begin
      if (resolve_valid) begin
        r_pht[w_res_idx] <= resolve_taken ? f_sat_inc(r_pht[w_res_idx])
                                          : f_sat_dec(r_pht[w_res_idx]);
      end
      // Recovery wins: a same-cycle fetch shift belongs to the flushed path.
      if (w_recover) begin
        r_ghr <= {resolve_ghr[HIST_BITS-2:0], resolve_taken};
      end else if (pred_fire) begin
        r_ghr <= {r_ghr[HIST_BITS-2:0], pred_taken};
      end
      if (w_recover && (r_mcnt != {CNT_BITS{1'b1}})) begin
        r_mcnt <= r_mcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Randomized bench for gshare_branch_predictor with an integer-array reference model
// and a few hand-computed directed expectations.
module tb_gshare_branch_predictor;

  localparam int IB = 4;
  localparam int HB = 4;
  localparam int CB = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [31:0]   pred_pc;
  logic          pred_fire;
  logic          pred_taken;
  logic [HB-1:0] pred_ghr;
  logic          resolve_valid;
  logic [31:0]   resolve_pc;
  logic [HB-1:0] resolve_ghr;
  logic          resolve_taken;
  logic          resolve_mispred;
  logic [HB-1:0] ghr;
  logic [CB-1:0] mispred_count;

  int checks = 0;
  int errors = 0;

  int m_pht [16];
  int m_ghr;
  int m_cnt;

  gshare_branch_predictor #(.IDX_BITS(IB), .HIST_BITS(HB), .CNT_BITS(CB)) dut (
    .clock(clock), .reset_n(reset_n),
    .pred_pc(pred_pc), .pred_fire(pred_fire),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_ghr(resolve_ghr), .resolve_taken(resolve_taken),
    .resolve_mispred(resolve_mispred),
    .ghr(ghr), .mispred_count(mispred_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc, input int h);
    return ((pc >> 2) % 16) ^ (h % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_cnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    int pt;
    int ri;
    pt = (m_pht[idx_of(pred_pc, m_ghr)] >= 2) ? 1 : 0;
    if (resolve_valid) begin
      ri = idx_of(resolve_pc, int'(resolve_ghr));
      if (resolve_taken) m_pht[ri] = (m_pht[ri] < 3) ? m_pht[ri] + 1 : 3;
      else               m_pht[ri] = (m_pht[ri] > 0) ? m_pht[ri] - 1 : 0;
    end
    if (resolve_valid && resolve_mispred) begin
      m_ghr = (int'(resolve_ghr) * 2 + int'(resolve_taken)) % 16;
      m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end else if (pred_fire) begin
      m_ghr = (m_ghr * 2 + pt) % 16;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic idle();
    pred_pc = 32'h0; pred_fire = 1'b0;
    resolve_valid = 1'b0; resolve_pc = 32'h0; resolve_ghr = '0;
    resolve_taken = 1'b0; resolve_mispred = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [3:0] h,
                         input logic tk, input logic mp);
    resolve_valid = 1'b1; resolve_pc = pc; resolve_ghr = h;
    resolve_taken = tk; resolve_mispred = mp;
    tick();
    idle();
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check("pred_taken", {31'b0, pred_taken},
            (m_pht[idx_of(pred_pc, m_ghr)] >= 2) ? 32'd1 : 32'd0);
      check("pred_ghr", {28'b0, pred_ghr}, m_ghr);
      check("ghr", {28'b0, ghr}, m_ghr);
      check("mispred_count", {28'b0, mispred_count}, m_cnt);
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    pred_pc = 32'h1234_5678;
    #2;
    check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("rst_pred_ghr", {28'b0, pred_ghr}, 32'd0);
    check("rst_mcnt", {28'b0, mispred_count}, 32'd0);
    #10 reset_n = 1'b1;
    tick();
    idle();

    // Train entry 0 towards taken and past saturation.
    resolve(32'h40, 4'h0, 1'b1, 1'b0);
    resolve(32'h40, 4'h0, 1'b1, 1'b0);
    pred_pc = 32'h40; #1;
    check("t2_taken", {31'b0, pred_taken}, 32'd1);
    check("t2_model", m_pht[0], 3);
    for (int i = 0; i < 5; i++) resolve(32'h40, 4'h0, 1'b1, 1'b0);
    check("t3_sat_hi", m_pht[0], 3);
    resolve(32'h40, 4'h0, 1'b0, 1'b0);
    pred_pc = 32'h40; #1;
    check("t3_taken", {31'b0, pred_taken}, 32'd1);
    check("t3_model", m_pht[0], 2);

    // Speculative history shifts in the predicted direction.
    pred_pc = 32'h40; pred_fire = 1'b1; #1;
    check("t4_ghr0", {28'b0, pred_ghr}, 32'h0);
    tick();
    pred_pc = 32'h0; pred_fire = 1'b1; #1;
    check("t4_ghr1", {28'b0, pred_ghr}, 32'h1);
    tick();
    pred_pc = 32'h0; pred_fire = 1'b1; #1;
    check("t4_ghr2", {28'b0, pred_ghr}, 32'h2);
    tick();
    idle(); #1;
    check("t4_ghr3", {28'b0, ghr}, 32'h4);

    // Recovery beats a same-cycle fetch shift.
    pred_pc = 32'h40; pred_fire = 1'b1;
    resolve(32'h80, 4'b0101, 1'b1, 1'b1);
    #1;
    check("t5_ghr", {28'b0, ghr}, 32'hB);
    check("t5_mcnt", {28'b0, mispred_count}, 32'd1);

    // mispred without valid is ignored.
    resolve_mispred = 1'b1; resolve_ghr = 4'hF; tick(); idle(); #1;
    check("t5_novalid", {28'b0, mispred_count}, 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      pred_pc         = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      pred_fire       = 1'($urandom);
      resolve_valid   = ($urandom_range(0, 3) != 0);
      resolve_pc      = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      resolve_ghr     = 4'($urandom);
      resolve_taken   = ($urandom_range(0, 9) < 7);
      resolve_mispred = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle(); #1;
    check("sat_mcnt", {28'b0, mispred_count}, 32'd15);

    // Asynchronous reset between edges after training.
    pred_pc = 32'h40; pred_fire = 1'b0;
    for (int i = 0; i < 4; i++) resolve(32'h40, 4'(m_ghr), 1'b1, 1'b0);
    pred_pc = 32'h40; #1;
    check("t6_pre_taken", {31'b0, pred_taken}, 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_taken", {31'b0, pred_taken}, 32'd0);
    check("t6_ghr", {28'b0, ghr}, 32'd0);
    check("t6_mcnt", {28'b0, mispred_count}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
